// File: rtl/calc_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_entry_sequencer
// Description : Central controller of the calculator datapath. Turns decoded
//               keypad events into operand-register write/clear pulses,
//               latches the operator, starts the ALU, supervises its
//               completion (with a timeout) and selects the display source.
//               Holds no arithmetic of its own.
// Ports       : clk           - system clock, rising edge
//               clear         - asynchronous active-low reset
//               key_valid     - one-cycle key strobe
//               key_code[4:0] - 0x00-0x09 digit, 0x10-0x13 ADD/SUB/MUL/DIV,
//                               0x14 EQUAL, 0x15 CE, others ignored
//               alu_done      - ALU completion strobe
//               alu_error     - ALU error flag, qualified by alu_done
//               digit_val     - digit for the operand registers
//               digit_we1/2   - operand := operand*10 + digit_val
//               op1_clr/op2_clr - operand := 0
//               result_to_op1 - operand1 := ALU result
//               op_code[1:0]  - latched operator
//               alu_start     - ALU start pulse
//               result_load   - latch ALU result for display
//               disp_sel[1:0] - 0 op1, 1 op2, 2 result, 3 error
//               busy / err    - in EXEC / in ERROR
// Revision    : 1.0 - initial release
// ============================================================================
module calc_entry_sequencer #(
  parameter int MAX_DIGITS  = 8,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic       alu_done,
  input  logic       alu_error,
  output logic [3:0] digit_val,
  output logic       digit_we1,
  output logic       digit_we2,
  output logic       op1_clr,
  output logic       op2_clr,
  output logic       result_to_op1,
  output logic [1:0] op_code,
  output logic       alu_start,
  output logic       result_load,
  output logic [1:0] disp_sel,
  output logic       busy,
  output logic       err
);

  localparam int               c_tmo_w    = $clog2(ALU_TIMEOUT + 1);
  localparam logic [3:0]       c_max_dig  = 4'(MAX_DIGITS);
  // The counter is compared before it increments, so the error is taken on
  // the edge where it would reach ALU_TIMEOUT.
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(ALU_TIMEOUT - 1);

  localparam logic [1:0] c_disp_op1 = 2'd0;
  localparam logic [1:0] c_disp_op2 = 2'd1;
  localparam logic [1:0] c_disp_res = 2'd2;
  localparam logic [1:0] c_disp_err = 2'd3;

  typedef enum logic [2:0] {
    ST_ENTRY1  = 3'd0,
    ST_OP_WAIT = 3'd1,
    ST_ENTRY2  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RESULT  = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [c_tmo_w-1:0] r_tmo;
  // Repeat-EQUAL from RESULT loads operand1 first, then starts the ALU one
  // cycle later; this flag marks that deferred start while already in EXEC.
  logic               r_start_pend;

  logic w_is_digit;
  logic w_is_op;
  logic w_is_eq;
  logic w_is_ce;
  logic w_dig_ok;

  assign w_is_digit = key_valid && (key_code <= 5'h09);
  assign w_is_op    = key_valid && (key_code[4:2] == 3'b100);
  assign w_is_eq    = key_valid && (key_code == 5'h14);
  assign w_is_ce    = key_valid && (key_code == 5'h15);
  assign w_dig_ok   = (r_cnt < c_max_dig);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state       <= ST_ENTRY1;
      r_cnt         <= '0;
      r_tmo         <= '0;
      r_start_pend  <= 1'b0;
      digit_val     <= '0;
      digit_we1     <= 1'b0;
      digit_we2     <= 1'b0;
      op1_clr       <= 1'b0;
      op2_clr       <= 1'b0;
      result_to_op1 <= 1'b0;
      op_code       <= '0;
      alu_start     <= 1'b0;
      result_load   <= 1'b0;
      disp_sel      <= c_disp_op1;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      digit_we1     <= 1'b0;
      digit_we2     <= 1'b0;
      op1_clr       <= 1'b0;
      op2_clr       <= 1'b0;
      result_to_op1 <= 1'b0;
      alu_start     <= 1'b0;
      result_load   <= 1'b0;

      case (r_state)
        ST_ENTRY1: begin
          if (w_is_digit) begin
            if (w_dig_ok) begin
              digit_we1 <= 1'b1;
              digit_val <= key_code[3:0];
              r_cnt     <= r_cnt + 4'd1;
            end
          end else if (w_is_op) begin
            op_code <= key_code[1:0];
            op2_clr <= 1'b1;
            r_state <= ST_OP_WAIT;
          end else if (w_is_ce) begin
            op1_clr <= 1'b1;
            r_cnt   <= '0;
          end
        end

        ST_OP_WAIT: begin
          if (w_is_digit) begin
            digit_we2 <= 1'b1;
            digit_val <= key_code[3:0];
            r_cnt     <= 4'd1;
            disp_sel  <= c_disp_op2;
            r_state   <= ST_ENTRY2;
          end else if (w_is_op) begin
            op_code <= key_code[1:0];
          end else if (w_is_ce) begin
            op1_clr  <= 1'b1;
            op2_clr  <= 1'b1;
            r_cnt    <= '0;
            disp_sel <= c_disp_op1;
            r_state  <= ST_ENTRY1;
          end
        end

        ST_ENTRY2: begin
          if (w_is_digit) begin
            if (w_dig_ok) begin
              digit_we2 <= 1'b1;
              digit_val <= key_code[3:0];
              r_cnt     <= r_cnt + 4'd1;
            end
          end else if (w_is_eq) begin
            alu_start <= 1'b1;
            r_tmo     <= '0;
            busy      <= 1'b1;
            r_state   <= ST_EXEC;
          end else if (w_is_ce) begin
            op2_clr <= 1'b1;
            r_cnt   <= '0;
          end
        end

        ST_EXEC: begin
          if (r_start_pend) begin
            alu_start    <= 1'b1;
            r_start_pend <= 1'b0;
            r_tmo        <= '0;
          end else if (alu_done) begin
            busy <= 1'b0;
            if (alu_error) begin
              err      <= 1'b1;
              disp_sel <= c_disp_err;
              r_state  <= ST_ERROR;
            end else begin
              result_load <= 1'b1;
              disp_sel    <= c_disp_res;
              r_state     <= ST_RESULT;
            end
          end else if (r_tmo == c_tmo_last) begin
            busy     <= 1'b0;
            err      <= 1'b1;
            disp_sel <= c_disp_err;
            r_state  <= ST_ERROR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        ST_RESULT: begin
          if (w_is_digit) begin
            op1_clr   <= 1'b1;
            digit_we1 <= 1'b1;
            digit_val <= key_code[3:0];
            r_cnt     <= 4'd1;
            disp_sel  <= c_disp_op1;
            r_state   <= ST_ENTRY1;
          end else if (w_is_op) begin
            result_to_op1 <= 1'b1;
            op_code       <= key_code[1:0];
            op2_clr       <= 1'b1;
            disp_sel      <= c_disp_res;
            r_state       <= ST_OP_WAIT;
          end else if (w_is_eq) begin
            result_to_op1 <= 1'b1;
            r_start_pend  <= 1'b1;
            busy          <= 1'b1;
            r_state       <= ST_EXEC;
          end else if (w_is_ce) begin
            op1_clr  <= 1'b1;
            op2_clr  <= 1'b1;
            r_cnt    <= '0;
            disp_sel <= c_disp_op1;
            r_state  <= ST_ENTRY1;
          end
        end

        ST_ERROR: begin
          if (w_is_ce) begin
            op1_clr  <= 1'b1;
            op2_clr  <= 1'b1;
            r_cnt    <= '0;
            err      <= 1'b0;
            disp_sel <= c_disp_op1;
            r_state  <= ST_ENTRY1;
          end
        end

        default: begin
          r_state <= ST_ENTRY1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_entry_sequencer
// Description : Self-checking bench for calc_entry_sequencer. A reference
//               model tracks the calculator's phase, the digits typed into
//               the operand being entered, and the absolute edge at which the
//               ALU was started; every output is compared after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_entry_sequencer;

  localparam int MAX_DIGITS  = 8;
  localparam int ALU_TIMEOUT = 64;

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_SUB = 5'h11;
  localparam logic [4:0] K_DIV = 5'h13;
  localparam logic [4:0] K_EQ  = 5'h14;
  localparam logic [4:0] K_CE  = 5'h15;

  logic       clk       = 1'b0;
  logic       clear     = 1'b1;
  logic       key_valid = 1'b0;
  logic [4:0] key_code  = '0;
  logic       alu_done  = 1'b0;
  logic       alu_error = 1'b0;
  logic [3:0] digit_val;
  logic       digit_we1, digit_we2, op1_clr, op2_clr, result_to_op1;
  logic [1:0] op_code;
  logic       alu_start, result_load;
  logic [1:0] disp_sel;
  logic       busy, err;

  calc_entry_sequencer #(.MAX_DIGITS(MAX_DIGITS), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .clk(clk), .clear(clear), .key_valid(key_valid), .key_code(key_code),
    .alu_done(alu_done), .alu_error(alu_error), .digit_val(digit_val),
    .digit_we1(digit_we1), .digit_we2(digit_we2), .op1_clr(op1_clr),
    .op2_clr(op2_clr), .result_to_op1(result_to_op1), .op_code(op_code),
    .alu_start(alu_start), .result_load(result_load), .disp_sel(disp_sel),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {P_E1, P_OPW, P_E2, P_EXEC, P_RES, P_ERR} ph_t;
  ph_t        ph;
  int         digits[$];     // digits typed into the operand being entered
  int         edge_no;
  int         start_edge;
  bit         start_due;     // ALU start owed on the next edge
  logic [3:0] m_dval;
  logic [1:0] m_opc, m_disp;
  bit         m_we1, m_we2, m_c1, m_c2, m_r2o, m_start, m_load;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_we1, cnt_start, cnt_busy;

  task automatic model_reset();
    ph = P_E1; digits.delete(); start_due = 0; start_edge = 0;
    m_dval = '0; m_opc = '0; m_disp = 2'd0;
    {m_we1, m_we2, m_c1, m_c2, m_r2o, m_start, m_load} = '0;
  endtask

  task automatic model_edge(input logic kv, input logic [4:0] kc,
                            input logic dn, input logic ae);
    bit dig, op, eq, ce;
    edge_no++;
    {m_we1, m_we2, m_c1, m_c2, m_r2o, m_start, m_load} = '0;
    dig = kv && (kc <= 5'd9);
    op  = kv && (kc >= 5'h10) && (kc <= 5'h13);
    eq  = kv && (kc == K_EQ);
    ce  = kv && (kc == K_CE);
    case (ph)
      P_E1: begin
        if (dig) begin
          if (digits.size() < MAX_DIGITS) begin
            m_we1 = 1; m_dval = kc[3:0]; digits.push_back(int'(kc));
          end
        end else if (op) begin
          m_opc = 2'(kc - 5'h10); m_c2 = 1; ph = P_OPW;
        end else if (ce) begin
          m_c1 = 1; digits.delete();
        end
      end
      P_OPW: begin
        if (dig) begin
          m_we2 = 1; m_dval = kc[3:0]; digits.delete(); digits.push_back(int'(kc));
          m_disp = 2'd1; ph = P_E2;
        end else if (op) begin
          m_opc = 2'(kc - 5'h10);
        end else if (ce) begin
          m_c1 = 1; m_c2 = 1; digits.delete(); m_disp = 2'd0; ph = P_E1;
        end
      end
      P_E2: begin
        if (dig) begin
          if (digits.size() < MAX_DIGITS) begin
            m_we2 = 1; m_dval = kc[3:0]; digits.push_back(int'(kc));
          end
        end else if (eq) begin
          m_start = 1; start_edge = edge_no; ph = P_EXEC;
        end else if (ce) begin
          m_c2 = 1; digits.delete();
        end
      end
      P_EXEC: begin
        if (start_due) begin
          m_start = 1; start_edge = edge_no; start_due = 0;
        end else if (dn) begin
          if (ae) begin m_disp = 2'd3; ph = P_ERR; end
          else begin m_load = 1; m_disp = 2'd2; ph = P_RES; end
        end else if (edge_no - start_edge == ALU_TIMEOUT) begin
          m_disp = 2'd3; ph = P_ERR;
        end
      end
      P_RES: begin
        if (dig) begin
          m_c1 = 1; m_we1 = 1; m_dval = kc[3:0];
          digits.delete(); digits.push_back(int'(kc)); m_disp = 2'd0; ph = P_E1;
        end else if (op) begin
          m_r2o = 1; m_opc = 2'(kc - 5'h10); m_c2 = 1; m_disp = 2'd2; ph = P_OPW;
        end else if (eq) begin
          m_r2o = 1; start_due = 1; ph = P_EXEC;
        end else if (ce) begin
          m_c1 = 1; m_c2 = 1; digits.delete(); m_disp = 2'd0; ph = P_E1;
        end
      end
      P_ERR: begin
        if (ce) begin
          m_c1 = 1; m_c2 = 1; digits.delete(); m_disp = 2'd0; ph = P_E1;
        end
      end
      default: ph = P_E1;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("digit_val",     8'(digit_val),     8'(m_dval));
    chk("digit_we1",     8'(digit_we1),     8'(m_we1));
    chk("digit_we2",     8'(digit_we2),     8'(m_we2));
    chk("op1_clr",       8'(op1_clr),       8'(m_c1));
    chk("op2_clr",       8'(op2_clr),       8'(m_c2));
    chk("result_to_op1", 8'(result_to_op1), 8'(m_r2o));
    chk("op_code",       8'(op_code),       8'(m_opc));
    chk("alu_start",     8'(alu_start),     8'(m_start));
    chk("result_load",   8'(result_load),   8'(m_load));
    chk("disp_sel",      8'(disp_sel),      8'(m_disp));
    chk("busy",          8'(busy),          8'(ph == P_EXEC));
    chk("err",           8'(err),           8'(ph == P_ERR));
    cnt_we1   += int'(digit_we1);
    cnt_start += int'(alu_start);
    cnt_busy  += int'(busy);
  endtask

  // Called at a falling edge: drive, advance the model, check after the edge.
  task automatic step(input logic kv, input logic [4:0] kc,
                      input logic dn, input logic ae);
    key_valid = kv; key_code = kc; alu_done = dn; alu_error = ae;
    model_edge(kv, kc, dn, ae);
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic key(input logic [4:0] kc);
    step(1'b1, kc, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'h00, 1'b0, 1'b0);
  endtask

  task automatic zero_counts();
    cnt_we1 = 0; cnt_start = 0; cnt_busy = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    edge_no = 0;
    zero_counts();
    model_reset();
    #2 clear = 1'b0;
    #1 check_all();                     // reset values while clear is low
    @(negedge clk);
    clear = 1'b1;

    // 1 2 ADD 3 EQUAL, ALU finishes 5 cycles after start
    zero_counts();
    key(5'd1); key(5'd2); key(K_ADD); key(5'd3); key(K_EQ);
    idle(4);
    step(1'b0, 5'h00, 1'b1, 1'b0);
    chk("tp1_busy_cycles", 8'(cnt_busy), 8'd5);
    chk("tp1_start_count", 8'(cnt_start), 8'd1);
    chk("tp1_disp_result", 8'(disp_sel), 8'd2);

    // digit limit: nine 9s after CE give exactly eight writes
    key(K_CE);
    zero_counts();
    for (int i = 0; i < 9; i++) key(5'd9);
    chk("max_digits_we1", 8'(cnt_we1), 8'(MAX_DIGITS));

    // ALU error path, keys ignored in ERROR, CE recovers
    key(K_DIV); key(5'd0); key(K_EQ); idle(2);
    step(1'b0, 5'h00, 1'b1, 1'b1);
    chk("div_err_flag", 8'(err), 8'd1);
    chk("div_err_disp", 8'(disp_sel), 8'd3);
    key(5'd5);
    key(K_CE);
    chk("err_ce_disp", 8'(disp_sel), 8'd0);

    // timeout with no alu_done
    key(5'd4); key(K_ADD); key(5'd2); key(K_EQ);
    idle(ALU_TIMEOUT - 1);
    chk("tmo_still_busy", 8'(busy), 8'd1);
    idle(1);
    chk("tmo_err", 8'(err), 8'd1);
    key(K_CE);

    // alu_done exactly on the expiry cycle wins
    key(5'd6); key(K_SUB); key(5'd1); key(K_EQ);
    idle(ALU_TIMEOUT - 1);
    step(1'b0, 5'h00, 1'b1, 1'b0);
    chk("tmo_done_wins", 8'(result_load), 8'd1);

    // RESULT: repeat EQUAL, then operator, then a digit
    key(K_EQ);
    chk("rep_r2o1", 8'(result_to_op1), 8'd1);
    idle(1);
    chk("rep_start_next", 8'(alu_start), 8'd1);
    idle(1);
    step(1'b0, 5'h00, 1'b1, 1'b0);
    key(K_SUB);
    chk("res_sub_opcode", 8'(op_code), 8'd1);
    key(5'd3); key(K_EQ); idle(1);
    step(1'b0, 5'h00, 1'b1, 1'b0);
    key(5'd7);
    chk("res_digit_val", 8'(digit_val), 8'd7);

    // asynchronous clear in the middle of EXEC
    key(K_ADD); key(5'd1); key(K_EQ); idle(2);
    #2 clear = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    clear = 1'b1;
    step(1'b0, 5'h00, 1'b1, 1'b0);      // stray alu_done must be ignored

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [4:0] kc;
      logic kv, dn, ae;
      r  = $urandom_range(0, 99);
      kv = (r < 70);
      r  = $urandom_range(0, 99);
      if (r < 50)      kc = 5'($urandom_range(0, 9));
      else if (r < 70) kc = 5'($urandom_range(16, 19));
      else if (r < 82) kc = K_EQ;
      else if (r < 87) kc = K_CE;
      else if (r < 93) kc = 5'($urandom_range(10, 15));
      else             kc = 5'($urandom_range(22, 31));
      dn = ($urandom_range(0, 5) == 0);
      ae = ($urandom_range(0, 3) == 0);
      step(kv, kc, dn, ae);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_entry_sequencer.md
# calc_entry_sequencer

Central controller of the calculator datapath. It takes decoded keypad events and sequences operand entry, operator latching, ALU execution and result display. It drives the operand-register enables, the ALU start/done handshake and the display-source select. It owns no arithmetic itself; operand registers, ALU and display are separate blocks.

## Interface
- MAX_DIGITS, 8, maximum digits accepted per operand; further digits are ignored.
- ALU_TIMEOUT, 64, cycles allowed from alu_start to alu_done before declaring an error.

- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset (0 = reset).
- key_valid  in  1  one-cycle key event strobe.
- key_code  in  5  0x00–0x09 digit; 0x10 ADD, 0x11 SUB, 0x12 MUL, 0x13 DIV, 0x14 EQUAL, 0x15 CE; other codes ignored.
- alu_done  in  1  one-cycle ALU completion strobe.
- alu_error  in  1  ALU overflow/div-by-zero; sampled only with alu_done.
- digit_val  out  4  digit for the operand register, valid with digit_we1/digit_we2.
- digit_we1 / digit_we2  out  1  one-cycle pulse: operand1/operand2 := operand*10 + digit_val.
- op1_clr / op2_clr  out  1  one-cycle pulse: operand := 0. If it coincides with digit_weN, operand := digit_val.
- result_to_op1  out  1  one-cycle pulse: operand1 := ALU result.
- op_code  out  2  latched operator: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- alu_start  out  1  one-cycle pulse that starts the ALU on operand1 op_code operand2.
- result_load  out  1  one-cycle pulse that latches the ALU result into the display/result register.
- disp_sel  out  2  0 operand1, 1 operand2, 2 result, 3 error pattern.
- busy  out  1  high while in EXEC.
- err  out  1  high while in ERROR.

## Operation
- States:
  - ENTRY1: operand1 entry.
  - OP_WAIT: operator chosen, operand2 empty.
  - ENTRY2: operand2 entry.
  - EXEC: waiting for the ALU.
  - RESULT: result shown.
  - ERROR: error shown.
- Reset: state ENTRY1; every pulse output 0; op_code 0; disp_sel 0; busy 0; err 0; digit counter 0; timeout counter 0.
- The digit counter is 4 bits wide. A digit is accepted only when count < MAX_DIGITS; accepting it increments the count.
- ENTRY1:
  - digit: digit_we1 (if accepted).
  - operator: latch op_code, op2_clr, go to OP_WAIT.
  - EQUAL: ignored.
  - CE: op1_clr, count := 0.
- OP_WAIT:
  - digit: digit_we2, count := 1, disp_sel := 1, go to ENTRY2.
  - operator: replace op_code.
  - EQUAL: ignored.
  - CE: op1_clr, op2_clr, go to ENTRY1.
- ENTRY2:
  - digit: digit_we2 (if accepted).
  - operator: ignored; there is no implicit chaining.
  - EQUAL: alu_start, go to EXEC.
  - CE: op2_clr, count := 0.
- EXEC:
  - All keys are ignored and dropped; there is no queue.
  - alu_done with alu_error=0: result_load, disp_sel := 2, go to RESULT.
  - alu_done with alu_error=1: disp_sel := 3, go to ERROR.
  - Timeout expiry: disp_sel := 3, go to ERROR.
- RESULT:
  - digit: op1_clr + digit_we1 together, count := 1, disp_sel := 0, go to ENTRY1.
  - operator: result_to_op1, latch op_code, op2_clr, go to OP_WAIT, disp_sel := 2 held until the first operand2 digit.
  - EQUAL: result_to_op1, then alu_start the following cycle, go to EXEC. The repeat uses the same op_code and operand2.
  - CE: op1_clr, op2_clr, disp_sel := 0, go to ENTRY1.
- ERROR:
  - Only CE leaves: op1_clr, op2_clr, disp_sel := 0, go to ENTRY1.
  - All other keys are ignored.
- Unused key codes never change state or outputs.

## Timing
- Every output is registered. The response to a key sampled at edge N is visible after edge N, for exactly one cycle for pulses.
- Consecutive key_valid cycles are each processed; key_valid held high counts as one key per cycle.
- alu_start is exactly 1 cycle wide. The timeout counter clears on alu_start and increments each EXEC cycle.
- Timeout fires when the counter reaches ALU_TIMEOUT with no alu_done seen. If alu_done arrives in the same cycle, alu_done wins.
- alu_done outside EXEC is ignored.
- On EXEC exit, busy falls in the same cycle that result_load is asserted or err rises.
- clear asserted at any time, including mid-EXEC, forces the reset values immediately (asynchronously). Deassertion is synchronous to the clk edge.

## Test plan
- Reset, then keys 1,2,ADD,3,EQUAL, alu_done (err 0) after 5 cycles:
  - digit_we1 with 1, then 2.
  - op_code=0 and op2_clr.
  - digit_we2 with 3, disp_sel=1.
  - alu_start exactly once; busy for 5 cycles.
  - result_load, disp_sel=2.
- Nine digits 9 in ENTRY1 with MAX_DIGITS=8: exactly 8 digit_we1 pulses; the ninth produces no pulse.
- DIV, EQUAL, alu_done with alu_error=1: err=1, disp_sel=3. Then digit 5 → no output. Then CE → op1_clr+op2_clr, ENTRY1, disp_sel=0.
- EQUAL with no alu_done for ALU_TIMEOUT cycles → ERROR. Separately, alu_done arriving on the expiry cycle → RESULT.
- In RESULT:
  - EQUAL → result_to_op1, then alu_start one cycle later.
  - SUB → result_to_op1, op_code=1, OP_WAIT.
  - digit 7 → op1_clr and digit_we1 in the same cycle, with digit_val=7.
- clear pulled low mid-EXEC: all outputs return to reset values immediately, without waiting for a clock edge. A later alu_done is ignored.
